// File: rtl/icache_direct_if.sv
// Fetch-side and backing-memory signals of the direct-mapped instruction cache.
// The cache uses the slave modport; the fetch stage / memory model uses master.
interface icache_direct_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] PC_F;
    logic             req_F;
    logic [WIDTH-1:0] instr_F;
    logic             hit_F;
    logic             stall_F;
    logic             flush;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic [31:0]      hit_count;
    logic [31:0]      miss_count;

    modport master (
        output PC_F, req_F, flush, mem_ack, mem_rdata,
        input  instr_F, hit_F, stall_F, mem_req, mem_addr, hit_count, miss_count
    );

    modport slave (
        input  PC_F, req_F, flush, mem_ack, mem_rdata,
        output instr_F, hit_F, stall_F, mem_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with combinational hit path and a
// line-refill FSM. Define ICACHE_STATS_EN to build the saturating hit/miss counters.
module icache_direct #(
    parameter int WIDTH          = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic           clk,
    input  logic           rst,
    icache_direct_if.slave bus
);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = WIDTH - TAG_LSB;
    localparam logic [WIDTH-1:0] NOP       = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] LINE_MASK = ~(WIDTH'(WORDS_PER_LINE * 4 - 1));

    typedef enum logic [1:0] {IDLE, REFILL, DONE} state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [WIDTH-1:0]   base_q, base_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic               abort_q, abort_d;

    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [WIDTH-1:0]   data_q [LINES][WORDS_PER_LINE];

    logic [IDX_W-1:0]   pc_idx, fill_idx;
    logic [OFF_W-1:0]   pc_off;
    logic [TAG_W-1:0]   pc_tag;
    logic               hit, beat_done, last_beat, fill_we, tag_we;
    logic [1:0]         unused_pc_bits;

    assign pc_off         = bus.PC_F[2 +: OFF_W];
    assign pc_idx         = bus.PC_F[2 + OFF_W +: IDX_W];
    assign pc_tag         = bus.PC_F[TAG_LSB +: TAG_W];
    assign fill_idx       = base_q[2 + OFF_W +: IDX_W];
    assign unused_pc_bits = bus.PC_F[1:0];

    // Lookup is only trusted in IDLE so a half-written line can never hit.
    assign hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && (state_q == IDLE);

    assign bus.hit_F    = bus.req_F & hit;
    assign bus.instr_F  = bus.hit_F ? data_q[pc_idx][pc_off] : NOP;
    assign bus.stall_F  = bus.req_F & ~bus.hit_F;
    assign bus.mem_req  = (state_q == REFILL);
    assign bus.mem_addr = bus.mem_req ? (base_q + (WIDTH'(beat_q) << 2)) : '0;

    assign beat_done = bus.mem_req & bus.mem_ack;
    assign last_beat = (beat_q == OFF_W'(WORDS_PER_LINE - 1));

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        base_d  = base_q;
        beat_d  = beat_q;
        abort_d = abort_q;
        fill_we = 1'b0;
        tag_we  = 1'b0;

        if (bus.flush) begin
            valid_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (!bus.flush && bus.req_F && !hit) begin
                    base_d  = bus.PC_F & LINE_MASK;
                    beat_d  = '0;
                    abort_d = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (bus.flush) begin
                    abort_d = 1'b1;
                end
                // A flush lets the in-flight beat finish, then abandons the line.
                if (beat_done) begin
                    fill_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (last_beat) begin
                        tag_we  = 1'b1;
                        if (!(abort_q || bus.flush)) begin
                            valid_d[fill_idx] = 1'b1;
                        end
                        state_d = DONE;
                    end else if (abort_q || bus.flush) begin
                        abort_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            base_q  <= '0;
            beat_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            abort_q <= abort_d;
        end
    end

    // Data and tag storage carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (rst && fill_we) begin
            data_q[fill_idx][beat_q] <= bus.mem_rdata;
        end
        if (rst && tag_we) begin
            tag_q[fill_idx] <= base_q[TAG_LSB +: TAG_W];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (bus.req_F && hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && (state_d == REFILL) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
`else
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: refill timing, hits, conflicts, slow memory,
// flush mid-refill and reset mid-refill, checked against hand-computed values.
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    int   checks    = 0;
    int   errors    = 0;

`ifdef ICACHE_STATS_EN
    localparam logic [31:0] EXP_HITS_AFTER_T2   = 32'd2;
    localparam logic [31:0] EXP_MISSES_AFTER_T2 = 32'd1;
`else
    localparam logic [31:0] EXP_HITS_AFTER_T2   = 32'd0;
    localparam logic [31:0] EXP_MISSES_AFTER_T2 = 32'd0;
`endif

    icache_direct_if #(.WIDTH(32)) bus ();

    icache_direct #(
        .WIDTH(32),
        .LINES(16),
        .WORDS_PER_LINE(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory model: word n holds 0x1000+n; ack after ack_delay waiting cycles.
    assign bus.mem_rdata = 32'h1000 + (bus.mem_addr >> 2);
    assign bus.mem_ack   = (ack_delay == 0) ? 1'b1 : (wait_cnt == ack_delay);

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge: presents pc, follows the miss to its hit cycle.
    task automatic miss_fill(input logic [31:0] pc, input int exp_stall,
                             input logic [31:0] exp_instr, input string tag);
        int          stalls = 0;
        int          beats  = 0;
        int          guard  = 0;
        logic        prev_wait = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [31:0] base;
        base = pc & ~32'hF;
        bus.PC_F  = pc;
        bus.req_F = 1'b1;
        #1;
        while (bus.stall_F && guard < 100) begin
            stalls++;
            if (bus.mem_req) begin
                if (prev_wait) chk({tag, "_hold"}, bus.mem_addr, prev_addr);
                if (bus.mem_ack) begin
                    chk({tag, "_addr"}, bus.mem_addr, base + 32'(4 * beats));
                    beats++;
                end
                prev_wait = !bus.mem_ack;
                prev_addr = bus.mem_addr;
            end else begin
                prev_wait = 1'b0;
            end
            @(negedge clk);
            #1;
            guard++;
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        chk({tag, "_beats"}, 32'(beats), 32'd4);
        chk({tag, "_hit"}, 32'(bus.hit_F), 32'd1);
        chk({tag, "_instr"}, bus.instr_F, exp_instr);
    endtask

    initial begin
        bus.PC_F  = '0;
        bus.req_F = 1'b0;
        bus.flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_stall", 32'(bus.stall_F), 32'd0);
        chk("rst_hit", 32'(bus.hit_F), 32'd0);
        chk("rst_instr", bus.instr_F, 32'h13);
        chk("rst_hit_count", bus.hit_count, 32'd0);
        chk("rst_miss_count", bus.miss_count, 32'd0);

        // Cold miss at 0x0, zero-wait memory
        @(negedge clk);
        rst = 1'b1;
        miss_fill(32'h0, 6, 32'h1000, "cold0");

        // Same-line hit
        @(negedge clk);
        bus.PC_F = 32'h8;
        #1;
        chk("hit8_hit", 32'(bus.hit_F), 32'd1);
        chk("hit8_instr", bus.instr_F, 32'h1002);
        chk("hit8_mem_req", 32'(bus.mem_req), 32'd0);
        chk("hit8_stall", 32'(bus.stall_F), 32'd0);

        @(negedge clk);
        bus.req_F = 1'b0;
        #1;
        chk("noreq_stall", 32'(bus.stall_F), 32'd0);
        chk("noreq_mem_req", 32'(bus.mem_req), 32'd0);
        chk("hit_count_t2", bus.hit_count, EXP_HITS_AFTER_T2);
        chk("miss_count_t2", bus.miss_count, EXP_MISSES_AFTER_T2);

        // Conflict on index 0
        @(negedge clk);
        miss_fill(32'h100, 6, 32'h1040, "conf100");
        @(negedge clk);
        miss_fill(32'h0, 6, 32'h1000, "conf0");

        // Slow memory: 3 wait cycles per beat
        @(negedge clk);
        ack_delay = 3;
        miss_fill(32'h24, 18, 32'h1009, "slow24");
        @(negedge clk);
        ack_delay = 0;

        // Flush during beat 1 of a refill of 0x0
        miss_fill(32'h40, 6, 32'h1010, "pre40");
        @(negedge clk);
        miss_fill(32'h100, 6, 32'h1040, "evict0");
        @(negedge clk);
        bus.PC_F = 32'h0;
        #1;
        chk("fl_detect_stall", 32'(bus.stall_F), 32'd1);
        chk("fl_detect_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("fl_beat0_req", 32'(bus.mem_req), 32'd1);
        chk("fl_beat0_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("fl_beat1_addr", bus.mem_addr, 32'h4);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.req_F = 1'b0;
        #1;
        chk("fl_no_beat2", 32'(bus.mem_req), 32'd0);
        chk("fl_idle_stall", 32'(bus.stall_F), 32'd0);
        @(negedge clk);
        miss_fill(32'h40, 6, 32'h1010, "fl40");
        @(negedge clk);
        miss_fill(32'h0, 6, 32'h1000, "fl0");

        // Reset for one cycle in the middle of a refill
        @(negedge clk);
        bus.PC_F = 32'h100;
        #1;
        chk("rr_detect_stall", 32'(bus.stall_F), 32'd1);
        @(negedge clk);
        #1;
        chk("rr_refill_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.req_F = 1'b0;
        #1;
        chk("rr_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rr_mem_addr", bus.mem_addr, 32'd0);
        chk("rr_hit_count", bus.hit_count, 32'd0);
        chk("rr_miss_count", bus.miss_count, 32'd0);
        @(negedge clk);
        miss_fill(32'h40, 6, 32'h1010, "rr40");
        @(negedge clk);
        miss_fill(32'h0, 6, 32'h1000, "rr0");

        @(negedge clk);
        bus.req_F = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage's PC and a word-wide backing instruction memory.
- Hits return the instruction combinationally in the same cycle as the PC, as the existing combinational instruction memory does.
- Misses stall fetch while a refill FSM reads one full line from backing memory over a req/ack handshake.

Parameters:
- WIDTH, 32, data/address width in bits
- LINES, 16, number of cache lines (power of 2, ≥2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, active-low, synchronous
- PC_F  input  WIDTH  fetch address
- req_F  input  1  fetch request valid
- instr_F  output  WIDTH  fetched instruction
- hit_F  output  1  instr_F valid this cycle
- stall_F  output  1  fetch must hold PC; OR'd into the pipeline stall
- flush  input  1  invalidate entire cache (fence.i)
- mem_req  output  1  backing-memory read request
- mem_addr  output  WIDTH  word address of the requested beat
- mem_ack  input  1  beat accepted; mem_rdata valid
- mem_rdata  input  WIDTH  read data
- hit_count  output  32  hit counter (see Optional Feature)
- miss_count  output  32  miss counter (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Address split:
  - PC_F[1:0] ignored.
  - Word offset = next log2(WORDS_PER_LINE) bits.
  - Index = next log2(LINES) bits.
  - Tag = remaining upper bits.
- Storage: data array LINES×WORDS_PER_LINE×WIDTH; tag array; valid bit per line.
- Reset (rst=0 at an edge): state=IDLE, all valid=0, mem_req=0, mem_addr=0, beat counter=0, abort flag=0. Applies mid-refill; the outstanding beat is dropped.
- Hit condition: hit = valid[idx] & tag[idx]==tag(PC_F) & state==IDLE.
- Outputs (combinational):
  - hit_F = req_F & hit.
  - instr_F = data word when hit_F, else 32'h00000013 (NOP).
  - stall_F = req_F & !hit_F, including all REFILL and DONE cycles.
- FSM:
  - IDLE:
    - if flush: clear all valid; stay IDLE; no refill starts that cycle.
    - else if req_F & !hit: latch line base = PC_F with offset and byte bits zeroed; beat=0; go REFILL.
  - REFILL:
    - mem_req=1; mem_addr = base + 4*beat.
    - mem_addr is stable while mem_req=1 and mem_ack=0.
    - A beat completes on an edge with mem_req & mem_ack; mem_ack may be high in the same cycle mem_req rises.
    - On beat completion: write mem_rdata to data[idx][beat]; beat++.
    - On completion of the last beat (beat==WORDS_PER_LINE-1): write the tag, set valid[idx] unless abort is set, go DONE.
    - flush during REFILL: set abort, clear all valid. The current beat's handshake is held until ack. After that ack go IDLE: no further beats, line stays invalid.
  - DONE: mem_req=0; one cycle; clear abort; go IDLE.
- Zero-wait memory miss timing: detect cycle, 4 REFILL cycles, DONE, hit on the next cycle. Total stall_F = 6 cycles for WORDS_PER_LINE=4.
- PC_F change during REFILL: the refill completes for the latched base. The lookup after refill uses the current PC_F.
- req_F=0 in IDLE: no refill, stall_F=0.
- mem_req is never asserted outside REFILL.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - hit_count increments on each IDLE cycle with req_F & hit.
  - miss_count increments on each IDLE→REFILL transition.
  - Both are 32-bit, saturate at 0xFFFFFFFF, reset to 0, and are unaffected by flush.
- Undefined: both ports are tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, req_F=1, PC_F=0x0, mem_ack tied 1, memory word n=0x1000+n → mem_addr 0x0,0x4,0x8,0xC on consecutive cycles; stall_F high 6 cycles; then hit_F=1, instr_F=0x1000.
- After the above, PC_F=0x8 → hit_F=1 same cycle, instr_F=0x1002, mem_req stays 0.
- Conflict: PC_F=0x100 (same index, tag differs) → refill from 0x100..0x10C; PC_F=0x0 then misses again and refills.
- mem_ack delayed 3 cycles per beat → mem_req/mem_addr held stable while waiting; stall_F lasts 2+4×4=18 cycles; correct data afterwards.
- flush pulsed during beat 1 of refill of 0x0 → beat 1 completes, no beat 2 request, FSM returns to IDLE. The next fetch of 0x0 misses; a previously valid line at 0x40 also misses.
- rst=0 for one cycle mid-refill → mem_req=0 the next cycle, all lines invalid. With ICACHE_STATS_EN, counters read 0; after tests 1–2 counters read hit_count=2, miss_count=1.
